// File: rtl/background_vram_writer.sv
// ---------------------------------------------------------------------------
// background_vram_writer
//
// Queues CPU byte writes to background VRAM and replays them only while the
// video timing reports that VRAM may be written (blanking). It can also fill
// the 960-byte tile area of the nametable with a single value. The attribute
// bytes at 960..1023 are left to CPU writes.
//
// Address map for CPU requests:
//   0x000-0x1FF -> pattern memory (pmb_addr = address[8:0])
//   0x400-0x7FF -> nametable      (ntbl_addr = address[9:0])
//   anything else is dropped and raises the sticky unmapped_err flag.
//
// Ports:
//   clk           pixel clock
//   rst           asynchronous active-low reset
//   writable      high while VRAM may be written; registered before use
//   req_valid/req_ready/req_address/req_data   CPU write request handshake
//   fill_start    one-cycle pulse that starts a nametable fill
//   fill_value    tile byte written by the fill, latched at fill_start
//   fill_busy     high while a fill is pending or running
//   pmb_we/pmb_addr     pattern-memory write strobe and byte index
//   ntbl_we/ntbl_addr   nametable write strobe and byte index
//   wdata         write byte shared by both strobes
//   unmapped_err  sticky flag: an unmapped request was dropped
//   err_clr       clears unmapped_err (a same-cycle set wins)
// ---------------------------------------------------------------------------
module background_vram_writer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_address,
    input  logic [7:0]  req_data,
    input  logic        fill_start,
    input  logic [7:0]  fill_value,
    output logic        fill_busy,
    output logic        pmb_we,
    output logic [8:0]  pmb_addr,
    output logic        ntbl_we,
    output logic [9:0]  ntbl_addr,
    output logic [7:0]  wdata,
    output logic        unmapped_err,
    input  logic        err_clr
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [9:0] FILL_LAST = 10'd959;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL
    } state_t;

    state_t          state_reg;
    logic            writable_q;
    logic [19:0]     fifo_mem [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]  wr_ptr_reg;
    logic [PTR_W:0]  rd_ptr_reg;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [11:0]     head_addr;
    logic [7:0]      head_data;
    logic            head_is_pmb;
    logic            head_is_ntbl;
    logic            fill_accept;
    logic [7:0]      fill_value_reg;
    logic [9:0]      fill_idx_reg;
    logic            fill_pending_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // Ready depends only on pointer state, never on req_valid.
    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    // Pops happen only in DRAIN and only while the registered window is open.
    assign pop       = (state_reg == DRAIN) && writable_q && !fifo_empty;

    assign {head_addr, head_data} = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_is_pmb  = (head_addr[11:9] == 3'b000);
    assign head_is_ntbl = (head_addr[11:10] == 2'b01);

    // A new fill is refused while one is already pending or running.
    assign fill_accept = fill_start && !fill_busy;

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {req_address, req_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            writable_q <= 1'b0;
        end else begin
            writable_q <= writable;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            fill_busy        <= 1'b0;
            fill_pending_reg <= 1'b0;
            fill_value_reg   <= '0;
            fill_idx_reg     <= '0;
            pmb_we           <= 1'b0;
            pmb_addr         <= '0;
            ntbl_we          <= 1'b0;
            ntbl_addr        <= '0;
            wdata            <= '0;
            unmapped_err     <= 1'b0;
        end else begin
            // Strobes are single-cycle; address and data simply hold.
            pmb_we  <= 1'b0;
            ntbl_we <= 1'b0;

            // Cleared here first so that a set further down wins.
            if (err_clr) begin
                unmapped_err <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    // fill_busy stays high for the one IDLE cycle after the last
                    // fill write, unless a fill is already queued behind a drain.
                    if (!fill_pending_reg) begin
                        fill_busy <= 1'b0;
                    end
                    if (fill_pending_reg) begin
                        state_reg        <= FILL;
                        fill_pending_reg <= 1'b0;
                        fill_idx_reg     <= '0;
                    end else if (fill_accept) begin
                        state_reg      <= FILL;
                        fill_busy      <= 1'b1;
                        fill_value_reg <= fill_value;
                        fill_idx_reg   <= '0;
                    end else if (!fifo_empty && writable_q) begin
                        state_reg <= DRAIN;
                    end
                end

                DRAIN: begin
                    // A fill requested mid-drain waits until the drain ends.
                    if (fill_accept) begin
                        fill_pending_reg <= 1'b1;
                        fill_busy        <= 1'b1;
                        fill_value_reg   <= fill_value;
                    end
                    if (pop) begin
                        if (head_is_pmb) begin
                            pmb_we   <= 1'b1;
                            pmb_addr <= head_addr[8:0];
                            wdata    <= head_data;
                        end else if (head_is_ntbl) begin
                            ntbl_we   <= 1'b1;
                            ntbl_addr <= head_addr[9:0];
                            wdata     <= head_data;
                        end else begin
                            unmapped_err <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                FILL: begin
                    // The index only advances on cycles that actually write.
                    if (writable_q) begin
                        ntbl_we   <= 1'b1;
                        ntbl_addr <= fill_idx_reg;
                        wdata     <= fill_value_reg;
                        if (fill_idx_reg == FILL_LAST) begin
                            state_reg <= IDLE;
                        end else begin
                            fill_idx_reg <= fill_idx_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_background_vram_writer.sv
// ---------------------------------------------------------------------------
// Bench for background_vram_writer. Directed stimulus pushes the strobe it
// expects into a scoreboard queue; a monitor on the falling edge pops and
// compares every pmb_we/ntbl_we strobe the design produces.
// ---------------------------------------------------------------------------
module tb_background_vram_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        writable = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_address = '0;
    logic [7:0]  req_data = '0;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_value = '0;
    logic        fill_busy;
    logic        pmb_we;
    logic [8:0]  pmb_addr;
    logic        ntbl_we;
    logic [9:0]  ntbl_addr;
    logic [7:0]  wdata;
    logic        unmapped_err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       is_ntbl;
        logic [9:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_act;
    exp_t mon_exp;

    // Bench copy of the registered writable flag: wq_used is the value the
    // design saw at the most recent rising edge.
    logic wq_m = 1'b0;
    logic wq_used = 1'b0;

    // Directed table: request address/data and the hand-derived strobe.
    logic [11:0] t2_addr [8] = '{12'h010, 12'h401, 12'h1FF, 12'h7FF,
                                 12'h000, 12'h5A5, 12'h123, 12'h400};
    logic [7:0]  t2_data [8] = '{8'h30, 8'h31, 8'h32, 8'h33,
                                 8'h34, 8'h35, 8'h36, 8'h37};
    logic        t2_ntbl [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0]  t2_idx  [8] = '{10'd16, 10'd1, 10'd511, 10'd1023,
                                 10'd0, 10'h1A5, 10'h123, 10'd0};

    always #5 clk = ~clk;

    background_vram_writer #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .writable     (writable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_address  (req_address),
        .req_data     (req_data),
        .fill_start   (fill_start),
        .fill_value   (fill_value),
        .fill_busy    (fill_busy),
        .pmb_we       (pmb_we),
        .pmb_addr     (pmb_addr),
        .ntbl_we      (ntbl_we),
        .ntbl_addr    (ntbl_addr),
        .wdata        (wdata),
        .unmapped_err (unmapped_err),
        .err_clr      (err_clr)
    );

    always @(posedge clk) begin
        wq_used = wq_m;
        wq_m    = rst ? writable : 1'b0;
    end

    function automatic exp_t mk(input logic n, input logic [9:0] a, input logic [7:0] d);
        exp_t e;
        e.is_ntbl = n;
        e.addr    = a;
        e.data    = d;
        return e;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            $display("check %s ok: 0x%0h", name, actual);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (pmb_we || ntbl_we) begin
            mon_act.is_ntbl = ntbl_we;
            mon_act.addr    = ntbl_we ? ntbl_addr : {1'b0, pmb_addr};
            mon_act.data    = wdata;
            checks++;
            if (pmb_we && ntbl_we) begin
                errors++;
                $display("FAIL both_strobes: pmb_we=1 ntbl_we=1, required at most one");
            end else if (!wq_used) begin
                errors++;
                $display("FAIL strobe_closed_window: strobe addr=%0d while writable_q=0, required none",
                         mon_act.addr);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: ntbl=%0b addr=%0d data=0x%0h, required no strobe",
                         mon_act.is_ntbl, mon_act.addr, mon_act.data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe_match: got ntbl=%0b addr=%0d data=0x%0h, expected ntbl=%0b addr=%0d data=0x%0h",
                             mon_act.is_ntbl, mon_act.addr, mon_act.data,
                             mon_exp.is_ntbl, mon_exp.addr, mon_exp.data);
                end else begin
                    $display("strobe %s addr=%0d data=0x%0h", mon_act.is_ntbl ? "ntbl" : "pmb",
                             mon_act.addr, mon_act.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; leaves the bench at posedge+1 after acceptance.
    task automatic push(input logic [11:0] a, input logic [7:0] d);
        req_valid   = 1'b1;
        req_address = a;
        req_data    = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Returns at the falling edge on which a strobe is seen, bounded.
    task automatic wait_strobe(input int limit, output logic found);
        found = 1'b0;
        for (int c = 0; c < limit && !found; c++) begin
            @(negedge clk);
            if (pmb_we || ntbl_we) found = 1'b1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_fill_busy"}, fill_busy, 0);
        check({tag, "_pmb_we"}, pmb_we, 0);
        check({tag, "_ntbl_we"}, ntbl_we, 0);
        check({tag, "_pmb_addr"}, pmb_addr, 0);
        check({tag, "_ntbl_addr"}, ntbl_addr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_unmapped_err"}, unmapped_err, 0);
    endtask

    initial begin
        logic found;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b1;

        // Single pattern-memory write
        writable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(1'b0, 10'd5, 8'hA5));
        push(12'h005, 8'hA5);
        repeat (6) @(posedge clk);
        #1;
        check("single_write_drained", exp_q.size(), 0);

        // Fill FIFO with writes blocked, then release them
        writable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(t2_ntbl[i], t2_idx[i], t2_data[i]));
            push(t2_addr[i], t2_data[i]);
        end
        check("full_req_ready", req_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        check("blocked_pending", exp_q.size(), 8);
        writable = 1'b1;
        wait_strobe(10, found);
        check("drain_started", found, 1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check("drain_consecutive", pmb_we | ntbl_we, 1);
        end
        @(posedge clk);
        #1;
        check("drain_req_ready", req_ready, 1);
        check("drain_queue_empty", exp_q.size(), 0);

        // Unmapped requests
        push(12'h300, 8'h11);
        push(12'h200, 8'h12);
        repeat (5) @(posedge clk);
        #1;
        check("unmapped_set", unmapped_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("unmapped_cleared", unmapped_err, 0);

        // Set beats a simultaneous clear
        err_clr = 1'b1;
        push(12'h800, 8'h13);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("set_beats_clear", unmapped_err, 1);
        @(posedge clk);
        #1;
        check("clear_after_set", unmapped_err, 0);
        err_clr = 1'b0;

        // Attribute byte through the CPU path
        exp_q.push_back(mk(1'b1, 10'd960, 8'h03));
        push(12'h7C0, 8'h03);
        repeat (6) @(posedge clk);
        #1;
        check("attr_write_drained", exp_q.size(), 0);

        // Nametable fill with writable toggling 100 on / 100 off
        fill_value = 8'h1F;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        check("fill_busy_set", fill_busy, 1);
        for (int i = 0; i < 960; i++) exp_q.push_back(mk(1'b1, 10'(i), 8'h1F));
        exp_q.push_back(mk(1'b0, 10'd16, 8'h77));
        for (int c = 0; c < 3000 && fill_busy; c++) begin
            writable = ((c / 100) % 2) == 0;
            req_valid   = (c == 50);
            req_address = 12'h010;
            req_data    = 8'h77;
            fill_start  = (c == 60);
            fill_value  = 8'h55;
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        fill_start = 1'b0;
        check("fill_busy_cleared", fill_busy, 0);
        writable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("fill_queue_empty", exp_q.size(), 0);

        // Fill requested mid-drain, then reset at fill index 300
        writable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(1'b0, 10'd2, 8'hB2));
        exp_q.push_back(mk(1'b1, 10'd3, 8'hC3));
        push(12'h002, 8'hB2);
        push(12'h403, 8'hC3);
        writable = 1'b1;
        wait_strobe(10, found);
        check("pending_drain_started", found, 1);
        fill_value = 8'h22;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        check("pending_fill_busy", fill_busy, 1);
        for (int i = 0; i <= 300; i++) exp_q.push_back(mk(1'b1, 10'(i), 8'h22));
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (ntbl_we && ntbl_addr == 10'd300) found = 1'b1;
        end
        check("fill_reached_300", found, 1);
        #1;
        rst = 1'b0;
        #1;
        check_reset("midfill_rst");
        check("midfill_queue_empty", exp_q.size(), 0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_idle_busy", fill_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/background_vram_writer.md
BACKGROUND_VRAM_WRITER -- requirements
Module: background_vram_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, request FIFO entries (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  pixel clock (12.5875 MHz).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port writable  input  1  high while background VRAM may be written (blanking).
REQ-005 SHALL have port req_valid  input  1  CPU write request present.
REQ-006 SHALL have port req_ready  output  1  request FIFO can accept.
REQ-007 SHALL have port req_address  input  12  CPU VRAM byte address.
REQ-008 SHALL have port req_data  input  8  CPU write byte.
REQ-009 SHALL have port fill_start  input  1  one-cycle pulse: start nametable fill.
REQ-010 SHALL have port fill_value  input  8  tile byte written by fill.
REQ-011 SHALL have port fill_busy  output  1  fill in progress.
REQ-012 SHALL have port pmb_we  output  1  pattern-memory write strobe.
REQ-013 SHALL have port pmb_addr  output  9  pattern-memory byte index.
REQ-014 SHALL have port ntbl_we  output  1  nametable write strobe.
REQ-015 SHALL have port ntbl_addr  output  10  nametable byte index.
REQ-016 SHALL have port wdata  output  8  write byte for either strobe.
REQ-017 SHALL have port unmapped_err  output  1  sticky: unmapped request dropped.
REQ-018 SHALL have port err_clr  input  1  clears unmapped_err.

Function
REQ-019 SHALL map 0x000-0x1FF to PMB (pmb_addr=address[8:0]), 0x400-0x7FF to NTBL (ntbl_addr=address[9:0]); all other addresses unmapped.
REQ-020 SHALL accept a request on cycles with req_valid && req_ready; req_ready = FIFO not full, no combinational path from req_valid.
REQ-021 SHALL register writable into writable_q; VRAM strobes SHALL only issue from work selected while writable_q=1.
REQ-022 SHALL implement FSM IDLE, DRAIN, FILL; IDLE->FILL on fill_start; IDLE->DRAIN when FIFO non-empty and writable_q=1; DRAIN->IDLE when FIFO empty or writable_q=0; FILL->IDLE after last fill write.
REQ-023 SHALL in DRAIN pop one entry per cycle; mapped entry SHALL produce exactly one registered strobe (pmb_we or ntbl_we) with addr/wdata the cycle after pop.
REQ-024 SHALL drop unmapped entries on pop with no strobe and set unmapped_err the cycle after pop.
REQ-025 SHALL in FILL write fill_value to ntbl_addr 0..959 in increasing order, one per cycle while writable_q=1; pause with counter held while writable_q=0; never touch 960-1023.
REQ-026 SHALL latch fill_value at fill_start; fill_start while fill_busy=1 SHALL be ignored.
REQ-027 SHALL, if fill_start and a pop coincide in DRAIN, finish DRAIN to IDLE, then enter FILL (pending fill flag).
REQ-028 SHALL keep accepting requests during FILL; FIFO SHALL not drain until FILL ends.
REQ-029 SHALL assert fill_busy from the cycle after accepted fill_start until the cycle after the ntbl write to 959.
REQ-030 SHALL never assert pmb_we and ntbl_we together; strobes SHALL be single-cycle.
REQ-031 SHALL give err_clr priority below a same-cycle error set (set wins).
REQ-032 SHALL preserve FIFO order; a simultaneous push and pop on a full FIFO SHALL not occur (req_ready low when full).

Reset
REQ-033 SHALL on rst low, asynchronously: FSM=IDLE, FIFO empty, req_ready=1, fill_busy=0, pmb_we=0, ntbl_we=0, pmb_addr=0, ntbl_addr=0, wdata=0, unmapped_err=0, writable_q=0, pending fill cleared.
REQ-034 SHALL on reset mid-fill or mid-drain abandon the operation; queued requests are lost.

Verification
REQ-035 writable=1, push (0x005,0xA5) -> pmb_we=1, pmb_addr=5, wdata=0xA5 exactly once, no ntbl_we.
REQ-036 writable=0, push 8 requests -> req_ready=0 after 8th, no strobes; raise writable -> 8 strobes in push order on consecutive cycles.
REQ-037 push 0x300 -> no strobe, unmapped_err=1; err_clr pulse -> 0.
REQ-038 fill_start value 0x1F, writable toggled 100 on/100 off -> 960 ntbl_we writes 0..959 value 0x1F, none while writable_q=0, fill_busy then 0.
REQ-039 push 0x7C0 data 0x3 -> ntbl_we, ntbl_addr=960 (color byte); fill never writes 960.
REQ-040 assert rst during fill at index 300 -> all outputs reset values immediately, no further strobes.
